wb_stage: RTL and testbench

// Writeback stage of the core, directly upstream of the register file. Accepts
// ALU and load results from the execute/memory stage over a valid/ready handshake.

---
 rtl/wb_stage.sv | 173 +++++++++++++++++
 tb/tb_wb_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register file write port.
// Retires ALU results in one cycle and waits for, aligns and extends
// load responses; reports the pending load destination for hazard stalls.
//
// Ports:
//   clk, rst_i            clock, synchronous active-high reset
//   ex_valid_i/ex_ready_o upstream handshake
//   ex_rd_i, ex_result_i  destination register and ALU result
//   ex_is_load_i          result comes from the memory response
//   ex_ld_size_i          00 byte, 01 half, 1x word
//   ex_ld_unsigned_i      zero-extend sub-word loads
//   ex_addr_lsb_i         load address bits [1:0]
//   mem_rvalid_i          load response valid pulse
//   mem_rdata_i           aligned response word
//   mem_err_i             response error, qualified by mem_rvalid_i
//   rd_o, data_rd_o       register file write (rd_o==0 means no write)
//   load_pending_o        a load is outstanding
//   load_rd_o             destination of the outstanding load, else 0
//   err_o                 one-cycle pulse: misaligned, mem error, timeout
module wb_stage #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_result_i,
    input  logic        ex_is_load_i,
    input  logic [1:0]  ex_ld_size_i,
    input  logic        ex_ld_unsigned_i,
    input  logic [1:0]  ex_addr_lsb_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [4:0]  rd_o,
    output logic [31:0] data_rd_o,
    output logic        load_pending_o,
    output logic [4:0]  load_rd_o,
    output logic        err_o
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TLAST = TL[TW-1:0];

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] size;
        logic       uns;
        logic [1:0] lsb;
    } ld_info_t;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    ld_info_t        ld_q, ld_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d;

    logic            misal;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ld_data;

    // Misalignment of the incoming load request.
    always_comb begin
        misal = 1'b0;
        unique case (ex_ld_size_i)
            2'b00:   misal = 1'b0;
            2'b01:   misal = ex_addr_lsb_i[0];
            default: misal = (ex_addr_lsb_i != 2'b00);
        endcase
    end

    // Datum extraction from the response word using the captured request.
    always_comb begin
        byte_sel = mem_rdata_i[{ld_q.lsb, 3'b000} +: 8];
        half_sel = ld_q.lsb[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ld_data  = mem_rdata_i;
        unique case (ld_q.size)
            2'b00: begin
                if (ld_q.uns) ld_data = {24'b0, byte_sel};
                else          ld_data = {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                if (ld_q.uns) ld_data = {16'b0, half_sel};
                else          ld_data = {{16{half_sel[15]}}, half_sel};
            end
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ld_d    = ld_q;
        rd_d    = 5'd0;
        data_d  = 32'd0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Responses arriving here are stale and dropped.
                if (ex_valid_i) begin
                    if (!ex_is_load_i) begin
                        if (ex_rd_i != 5'd0) begin
                            rd_d   = ex_rd_i;
                            data_d = ex_result_i;
                        end
                    end else if (misal) begin
                        err_d = 1'b1;
                    end else begin
                        ld_d.rd   = ex_rd_i;
                        ld_d.size = ex_ld_size_i;
                        ld_d.uns  = ex_ld_unsigned_i;
                        ld_d.lsb  = ex_addr_lsb_i;
                        timer_d   = '0;
                        state_d   = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    if (mem_err_i) begin
                        err_d = 1'b1;
                    end else if (ld_q.rd != 5'd0) begin
                        rd_d   = ld_q.rd;
                        data_d = ld_data;
                    end
                end else if (TIMEOUT != 0 && timer_q == TLAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Free-running when TIMEOUT is 0; wrap is harmless.
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            ld_q    <= '0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign ex_ready_o     = (state_q == IDLE);
    assign load_pending_o = (state_q == WAIT_MEM);
    assign load_rd_o      = (state_q == WAIT_MEM) ? ld_q.rd : 5'd0;
    assign rd_o           = rd_q;
    assign data_rd_o      = data_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors for wb_stage with hand-computed results.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_result_i;
    logic        ex_is_load_i;
    logic [1:0]  ex_ld_size_i;
    logic        ex_ld_unsigned_i;
    logic [1:0]  ex_addr_lsb_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic [4:0]  rd_o;
    logic [31:0] data_rd_o;
    logic        load_pending_o;
    logic [4:0]  load_rd_o;
    logic        err_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_rd_i          (ex_rd_i),
        .ex_result_i      (ex_result_i),
        .ex_is_load_i     (ex_is_load_i),
        .ex_ld_size_i     (ex_ld_size_i),
        .ex_ld_unsigned_i (ex_ld_unsigned_i),
        .ex_addr_lsb_i    (ex_addr_lsb_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_err_i        (mem_err_i),
        .rd_o             (rd_o),
        .data_rd_o        (data_rd_o),
        .load_pending_o   (load_pending_o),
        .load_rd_o        (load_rd_o),
        .err_o            (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] res);
        ex_valid_i   = 1'b1;
        ex_is_load_i = 1'b0;
        ex_rd_i      = rd;
        ex_result_i  = res;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [1:0] sz,
                      input logic uns, input logic [1:0] lsb);
        ex_valid_i       = 1'b1;
        ex_is_load_i     = 1'b1;
        ex_rd_i          = rd;
        ex_ld_size_i     = sz;
        ex_ld_unsigned_i = uns;
        ex_addr_lsb_i    = lsb;
        ex_result_i      = 32'h5555_5555;
    endtask

    task automatic idle_in();
        ex_valid_i   = 1'b0;
        ex_is_load_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d, input logic e);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        mem_err_i    = e;
    endtask

    // Load request, one quiet wait cycle, then a good response.
    task automatic ld_case(input string tag, input logic [4:0] rd,
                           input logic [1:0] sz, input logic uns,
                           input logic [1:0] lsb, input logic [31:0] d,
                           input logic [31:0] exp);
        ld(rd, sz, uns, lsb);
        step();
        chk({tag, ".ready"}, 32'(ex_ready_o), 32'd0);
        chk({tag, ".pend"}, 32'(load_pending_o), 32'd1);
        chk({tag, ".ldrd"}, 32'(load_rd_o), 32'(rd));
        idle_in();
        step();
        chk({tag, ".wait_rd"}, 32'(rd_o), 32'd0);
        resp(d, 1'b0);
        step();
        chk({tag, ".rd"}, 32'(rd_o), 32'(rd));
        chk({tag, ".data"}, data_rd_o, exp);
        chk({tag, ".ready2"}, 32'(ex_ready_o), 32'd1);
        idle_in();
        step();
        chk({tag, ".rd_clr"}, 32'(rd_o), 32'd0);
    endtask

    initial begin
        rst_i            = 1'b1;
        ex_rd_i          = 5'd0;
        ex_result_i      = 32'd0;
        ex_ld_size_i     = 2'b00;
        ex_ld_unsigned_i = 1'b0;
        ex_addr_lsb_i    = 2'b00;
        mem_rdata_i      = 32'd0;
        idle_in();
        step();
        step();
        chk("rst.rd", 32'(rd_o), 32'd0);
        chk("rst.data", data_rd_o, 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        chk("rst.ready", 32'(ex_ready_o), 32'd1);
        chk("rst.pend", 32'(load_pending_o), 32'd0);
        rst_i = 1'b0;
        step();

        alu(5'd5, 32'hDEAD_BEEF);
        step();
        chk("alu.rd", 32'(rd_o), 32'd5);
        chk("alu.data", data_rd_o, 32'hDEAD_BEEF);
        idle_in();
        step();
        chk("alu.rd_clr", 32'(rd_o), 32'd0);

        ld_case("lb3", 5'd7, 2'b00, 1'b0, 2'd3, 32'h8011_2233, 32'hFFFF_FF80);
        ld_case("lhu2", 5'd12, 2'b01, 1'b1, 2'd2, 32'h8001_ABCD,
                32'h0000_8001);
        ld_case("lh0", 5'd3, 2'b01, 1'b0, 2'd0, 32'h1234_F00D, 32'hFFFF_F00D);
        ld_case("lbu1", 5'd4, 2'b00, 1'b1, 2'd1, 32'h0000_A500, 32'h0000_00A5);
        ld_case("lw", 5'd31, 2'b10, 1'b1, 2'd0, 32'h8765_4321, 32'h8765_4321);

        ld(5'd8, 2'b10, 1'b0, 2'd1);
        step();
        chk("mis_w.err", 32'(err_o), 32'd1);
        chk("mis_w.rd", 32'(rd_o), 32'd0);
        chk("mis_w.pend", 32'(load_pending_o), 32'd0);
        ld(5'd8, 2'b01, 1'b0, 2'd3);
        step();
        chk("mis_h.err", 32'(err_o), 32'd1);
        chk("mis_h.ready", 32'(ex_ready_o), 32'd1);
        idle_in();
        step();
        chk("mis.err_clr", 32'(err_o), 32'd0);

        ld(5'd9, 2'b10, 1'b0, 2'd0);
        step();
        idle_in();
        resp(32'h1111_1111, 1'b1);
        step();
        chk("merr.err", 32'(err_o), 32'd1);
        chk("merr.rd", 32'(rd_o), 32'd0);
        chk("merr.ready", 32'(ex_ready_o), 32'd1);
        idle_in();
        step();
        chk("merr.err_clr", 32'(err_o), 32'd0);

        ld(5'd10, 2'b10, 1'b0, 2'd0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tmo.wait_err", 32'(err_o), 32'd0);
            chk("tmo.wait_pend", 32'(load_pending_o), 32'd1);
        end
        step();
        chk("tmo.err", 32'(err_o), 32'd1);
        chk("tmo.rd", 32'(rd_o), 32'd0);
        chk("tmo.ready", 32'(ex_ready_o), 32'd1);
        resp(32'hCAFE_F00D, 1'b0);
        step();
        chk("late.rd", 32'(rd_o), 32'd0);
        chk("late.err", 32'(err_o), 32'd0);
        idle_in();
        step();

        ld(5'd11, 2'b10, 1'b0, 2'd0);
        step();
        chk("rstw.pend", 32'(load_pending_o), 32'd1);
        idle_in();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rstw.rd", 32'(rd_o), 32'd0);
        chk("rstw.ready", 32'(ex_ready_o), 32'd1);
        chk("rstw.err", 32'(err_o), 32'd0);
        resp(32'h2222_2222, 1'b0);
        step();
        chk("rstw.late_rd", 32'(rd_o), 32'd0);
        chk("rstw.late_err", 32'(err_o), 32'd0);
        idle_in();

        for (int i = 1; i <= 3; i++) begin
            alu(5'(i), 32'(i * 32'h11));
            chk("b2b.ready", 32'(ex_ready_o), 32'd1);
            step();
            chk("b2b.rd", 32'(rd_o), 32'(i));
            chk("b2b.data", data_rd_o, 32'(i * 32'h11));
        end
        idle_in();
        step();
        chk("b2b.rd_clr", 32'(rd_o), 32'd0);

        alu(5'd0, 32'h0000_00FF);
        step();
        chk("x0alu.rd", 32'(rd_o), 32'd0);
        ld(5'd0, 2'b10, 1'b0, 2'd0);
        step();
        chk("x0ld.pend", 32'(load_pending_o), 32'd1);
        chk("x0ld.ready", 32'(ex_ready_o), 32'd0);
        chk("x0ld.ldrd", 32'(load_rd_o), 32'd0);
        idle_in();
        resp(32'h3333_3333, 1'b0);
        step();
        chk("x0ld.rd", 32'(rd_o), 32'd0);
        chk("x0ld.ready2", 32'(ex_ready_o), 32'd1);
        idle_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
